crc_stream_engine: RTL and testbench

//  Parametrised successor to the fixed byte-wide CRC-16 block. Computes any CRC up to 32 bits
//  (polynomial, init, reflection, xorout are parameters) over frames of DATA_W-bit beats.

---
 rtl/crc_stream_engine.sv | 132 +++++++++++++
 tb/tb_crc_stream_engine.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: generic CRC up to 32 bits over DATA_W-bit beats with valid/ready
// handshakes, partial last beats and a residue-check flag for RX frames.
module crc_stream_engine #(
    parameter int          CRC_W   = 16,
    parameter logic [31:0] POLY    = 32'h0000_1021,
    parameter logic [31:0] INIT    = 32'h0000_FFFF,
    parameter bit          REFIN   = 1'b0,
    parameter bit          REFOUT  = 1'b0,
    parameter logic [31:0] XOROUT  = 32'h0000_0000,
    parameter int          DATA_W  = 8,
    parameter logic [31:0] RESIDUE = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_sof,
    input  logic                        in_eof,
    input  logic [$clog2(DATA_W/8):0]   in_nbytes,
    output logic                        crc_valid,
    input  logic                        crc_ready,
    output logic [CRC_W-1:0]            crc_out,
    output logic                        crc_ok
);

    localparam int NB  = DATA_W / 8;
    localparam int NBW = $clog2(NB) + 1;

    localparam logic [CRC_W-1:0] POLY_T    = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_T    = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_T  = XOROUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] RESIDUE_T = RESIDUE[CRC_W-1:0];
    localparam logic [NBW-1:0]   NB_L      = NBW'(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CRC_W-1:0]   crc_out_q;
    logic               crc_ok_q;
    logic               load_res;
    logic               accept;
    logic [NBW-1:0]     act_lanes;
    logic [NB-1:0]      lane_en;

    // Bit-serial LFSR unrolled over every enabled lane; lane 0 is the oldest byte.
    function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] crc_in,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [NB-1:0]     en);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = 0; i < NB; i++) begin
            if (en[i]) begin
                for (int j = 0; j < 8; j++) begin
                    fb = c[CRC_W-1] ^ (REFIN ? data[8*i+j] : data[8*i+7-j]);
                    c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_T : '0);
                end
            end
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] crc_final(input logic [CRC_W-1:0] raw);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = REFOUT ? raw[CRC_W-1-i] : raw[i];
        end
        return r ^ XOROUT_T;
    endfunction

    assign crc_valid = (state_q == S_DONE);
    assign in_ready  = !crc_valid || crc_ready;
    assign accept    = in_valid && in_ready;
    assign crc_out   = crc_out_q;
    assign crc_ok    = crc_ok_q;

    // Out-of-range lane counts fall back to a full beat.
    always_comb begin
        act_lanes = NB_L;
        if (in_eof && in_nbytes != '0 && in_nbytes <= NB_L) begin
            act_lanes = in_nbytes;
        end
        for (int i = 0; i < NB; i++) begin
            lane_en[i] = (NBW'(i) < act_lanes);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        load_res = 1'b0;
        if (state_q == S_DONE && crc_ready) begin
            state_d = S_IDLE;
        end
        if (accept) begin
            if (in_sof) begin
                crc_d    = crc_update(INIT_T, in_data, lane_en);
                state_d  = in_eof ? S_DONE : S_ACCUM;
                load_res = in_eof;
            end else if (state_q == S_ACCUM) begin
                crc_d    = crc_update(crc_q, in_data, lane_en);
                state_d  = in_eof ? S_DONE : S_ACCUM;
                load_res = in_eof;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            crc_q     <= INIT_T;
            crc_out_q <= '0;
            crc_ok_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            if (load_res) begin
                crc_out_q <= crc_final(crc_d);
                crc_ok_q  <= (crc_d == RESIDUE_T);
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench: three engine configurations (CRC-16/CCITT-FALSE x8, CRC-32 x32,
// CRC-16/ARC x16) against a byte-wise reference CRC model.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Configuration A: defaults, byte-wide beats
    logic        a_valid = 0, a_ready, a_sof = 0, a_eof = 0, a_cvalid, a_cready = 1, a_ok;
    logic [7:0]  a_data = '0;
    logic [0:0]  a_nb = '0;
    logic [15:0] a_crc;

    // Configuration B: CRC-32, 32-bit beats
    logic        b_valid = 0, b_ready, b_sof = 0, b_eof = 0, b_cvalid, b_cready = 1, b_ok;
    logic [31:0] b_data = '0;
    logic [2:0]  b_nb = '0;
    logic [31:0] b_crc;

    // Configuration C: CRC-16/ARC, 16-bit beats
    logic        c_valid = 0, c_ready, c_sof = 0, c_eof = 0, c_cvalid, c_cready = 1, c_ok;
    logic [15:0] c_data = '0;
    logic [1:0]  c_nb = '0;
    logic [15:0] c_crc;

    crc_stream_engine dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_sof(a_sof), .in_eof(a_eof), .in_nbytes(a_nb), .crc_valid(a_cvalid),
        .crc_ready(a_cready), .crc_out(a_crc), .crc_ok(a_ok)
    );

    crc_stream_engine #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1),
        .XOROUT(32'hFFFFFFFF), .DATA_W(32)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_sof(b_sof), .in_eof(b_eof), .in_nbytes(b_nb), .crc_valid(b_cvalid),
        .crc_ready(b_cready), .crc_out(b_crc), .crc_ok(b_ok)
    );

    crc_stream_engine #(
        .CRC_W(16), .POLY(32'h8005), .INIT(32'h0), .REFIN(1'b1), .REFOUT(1'b1), .DATA_W(16)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
        .in_sof(c_sof), .in_eof(c_eof), .in_nbytes(c_nb), .crc_valid(c_cvalid),
        .crc_ready(c_cready), .crc_out(c_crc), .crc_ok(c_ok)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: classic byte-at-a-time CRC (byte XORed into the top of the register).
    function automatic logic [31:0] crc_model(input logic [7:0] msg[$], input int w,
                                              input logic [31:0] poly, input logic [31:0] init,
                                              input bit refin, input bit refout,
                                              input logic [31:0] xorout, output logic [31:0] raw);
        longint unsigned mask, r, p, t;
        logic [7:0] b, rb;
        mask = (64'd1 << w) - 64'd1;
        r = 64'(init) & mask;
        p = 64'(poly) & mask;
        foreach (msg[k]) begin
            b = msg[k];
            for (int j = 0; j < 8; j++) rb[j] = b[7-j];
            if (refin) b = rb;
            r = r ^ (64'(b) << (w - 8));
            for (int j = 0; j < 8; j++) begin
                if (((r >> (w - 1)) & 64'd1) != 0) r = ((r << 1) ^ p) & mask;
                else r = (r << 1) & mask;
            end
        end
        raw = 32'(r);
        if (refout) begin
            t = 0;
            for (int j = 0; j < w; j++)
                if (((r >> j) & 64'd1) != 0) t = t | (64'd1 << (w - 1 - j));
            r = t;
        end
        return 32'((r ^ 64'(xorout)) & mask);
    endfunction

    task automatic a_beat(input logic [7:0] d, input bit s, input bit e);
        a_valid = 1; a_data = d; a_sof = s; a_eof = e; a_nb = 1'($urandom);
        @(negedge clk);
        a_valid = 0; a_sof = 0; a_eof = 0;
    endtask

    task automatic a_frame(input logic [7:0] msg[$], input bit gaps);
        for (int k = 0; k < msg.size(); k++) begin
            a_beat(msg[k], k == 0, k == msg.size() - 1);
            if (gaps && k != msg.size() - 1 && $urandom_range(0, 2) == 0) begin
                a_data = 8'($urandom); a_sof = 1'($urandom);
                @(negedge clk);
                a_sof = 0;
            end
        end
    endtask

    task automatic b_frame(input logic [7:0] msg[$], input bit gaps);
        int n, nbeats, lanes;
        logic [31:0] d;
        logic [2:0]  nb;
        n = msg.size();
        nbeats = (n + 3) / 4;
        for (int k = 0; k < nbeats; k++) begin
            d = $urandom;
            lanes = (k == nbeats - 1) ? n - 4 * k : 4;
            for (int l = 0; l < lanes; l++) d[8*l+:8] = msg[4*k+l];
            if (k != nbeats - 1) nb = 3'($urandom);
            else if (lanes == 4 && gaps) nb = 3'($urandom_range(4, 8));
            else nb = 3'(lanes);
            b_valid = 1; b_data = d; b_sof = (k == 0); b_eof = (k == nbeats - 1); b_nb = nb;
            @(negedge clk);
            b_valid = 0; b_sof = 0; b_eof = 0;
            if (gaps && k != nbeats - 1 && $urandom_range(0, 2) == 0) @(negedge clk);
        end
    endtask

    task automatic c_frame(input logic [7:0] msg[$], input bit gaps);
        int n, nbeats, lanes;
        logic [15:0] d;
        logic [1:0]  nb;
        n = msg.size();
        nbeats = (n + 1) / 2;
        for (int k = 0; k < nbeats; k++) begin
            d = 16'($urandom);
            lanes = (k == nbeats - 1) ? n - 2 * k : 2;
            for (int l = 0; l < lanes; l++) d[8*l+:8] = msg[2*k+l];
            if (k != nbeats - 1) nb = 2'($urandom);
            else if (lanes == 2 && gaps) nb = 2'($urandom_range(2, 4));
            else nb = 2'(lanes);
            c_valid = 1; c_data = d; c_sof = (k == 0); c_eof = (k == nbeats - 1); c_nb = nb;
            @(negedge clk);
            c_valid = 0; c_sof = 0; c_eof = 0;
            if (gaps && k != nbeats - 1 && $urandom_range(0, 2) == 0) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  q123[$];
        logic [7:0]  msg[$];
        logic [31:0] raw, exp;

        q123 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a_cvalid", 32'(a_cvalid), 32'd0);
        check("rst_a_crc", 32'(a_crc), 32'd0);
        check("rst_a_ok", 32'(a_ok), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_b_crc", b_crc, 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        rst_n = 1;
        @(negedge clk);

        // Check value "123456789", byte beats; valid only after the eof beat
        for (int k = 0; k < 8; k++) a_beat(q123[k], k == 0, 1'b0);
        check("t1_no_early_valid", 32'(a_cvalid), 32'd0);
        a_beat(q123[8], 1'b0, 1'b1);
        check("t1_cvalid", 32'(a_cvalid), 32'd1);
        check("t1_crc", 32'(a_crc), 32'h29B1);
        exp = crc_model(q123, 16, 32'h1021, 32'hFFFF, 0, 0, 32'h0, raw);
        check("t1_crc_model", 32'(a_crc), exp);
        @(negedge clk);
        check("t1_cvalid_drop", 32'(a_cvalid), 32'd0);

        // CRC-32 on 32-bit beats, last beat one lane
        b_frame(q123, 1'b0);
        check("t2_cvalid", 32'(b_cvalid), 32'd1);
        check("t2_crc", b_crc, 32'hCBF43926);

        // CRC-16/ARC on 16-bit beats, last beat one lane
        c_frame(q123, 1'b0);
        check("t3_cvalid", 32'(c_cvalid), 32'd1);
        check("t3_crc", 32'(c_crc), 32'hBB3D);
        @(negedge clk);

        // Residue check: appended CRC gives ok, a flipped bit does not
        msg = q123;
        msg.push_back(8'h29);
        msg.push_back(8'hB1);
        a_frame(msg, 1'b0);
        check("t4_ok", 32'(a_ok), 32'd1);
        msg[3] = msg[3] ^ 8'h04;
        a_frame(msg, 1'b0);
        exp = crc_model(msg, 16, 32'h1021, 32'hFFFF, 0, 0, 32'h0, raw);
        check("t4_bad_ok", 32'(a_ok), 32'd0);
        check("t4_bad_crc", 32'(a_crc), exp);
        @(negedge clk);

        // Backpressure: result held, input stalled, then back-to-back frame on handshake
        a_cready = 0;
        a_frame(q123, 1'b0);
        for (int k = 0; k < 5; k++) begin
            a_valid = 1; a_data = 8'h55; a_sof = 1; a_eof = 1;
            check("t5_ready_low", 32'(a_ready), 32'd0);
            check("t5_cvalid_held", 32'(a_cvalid), 32'd1);
            check("t5_crc_held", 32'(a_crc), 32'h29B1);
            @(negedge clk);
        end
        a_cready = 1;
        a_beat(8'h41, 1'b1, 1'b1);
        msg = {8'h41};
        exp = crc_model(msg, 16, 32'h1021, 32'hFFFF, 0, 0, 32'h0, raw);
        check("t5_b2b_cvalid", 32'(a_cvalid), 32'd1);
        check("t5_b2b_crc", 32'(a_crc), exp);
        @(negedge clk);
        check("t5_cvalid_drop", 32'(a_cvalid), 32'd0);

        // Non-sof beat in IDLE is dropped
        a_beat(8'h77, 1'b0, 1'b1);
        check("t6_drop_nosof", 32'(a_cvalid), 32'd0);

        // Reset mid-frame, then a clean frame
        for (int k = 0; k < 4; k++) a_beat(q123[k], k == 0, 1'b0);
        rst_n = 0;
        #3;
        check("t6_rst_cvalid", 32'(a_cvalid), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("t6_post_rst_cvalid", 32'(a_cvalid), 32'd0);
        a_frame(q123, 1'b0);
        check("t6_crc", 32'(a_crc), 32'h29B1);

        // Sof mid-frame restarts from INIT
        a_beat(8'h61, 1'b1, 1'b0);
        a_beat(8'h62, 1'b0, 1'b0);
        a_frame(q123, 1'b0);
        check("t6_restart_crc", 32'(a_crc), 32'h29B1);
        @(negedge clk);

        // Randomized frames with gaps, garbage lanes and out-of-range lane counts
        for (int t = 0; t < 15; t++) begin
            msg = {};
            for (int k = 0; k < $urandom_range(1, 24); k++) msg.push_back(8'($urandom));
            a_frame(msg, 1'b1);
            exp = crc_model(msg, 16, 32'h1021, 32'hFFFF, 0, 0, 32'h0, raw);
            check("rand_a_crc", 32'(a_crc), exp);
            check("rand_a_ok", 32'(a_ok), 32'(raw[15:0] == 16'h0));
        end
        @(negedge clk);
        for (int t = 0; t < 15; t++) begin
            msg = {};
            for (int k = 0; k < $urandom_range(1, 24); k++) msg.push_back(8'($urandom));
            b_frame(msg, 1'b1);
            exp = crc_model(msg, 32, 32'h04C11DB7, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, raw);
            check("rand_b_cvalid", 32'(b_cvalid), 32'd1);
            check("rand_b_crc", b_crc, exp);
            check("rand_b_ok", 32'(b_ok), 32'(raw == 32'h0));
        end
        @(negedge clk);
        for (int t = 0; t < 15; t++) begin
            msg = {};
            for (int k = 0; k < $urandom_range(1, 24); k++) msg.push_back(8'($urandom));
            c_frame(msg, 1'b1);
            exp = crc_model(msg, 16, 32'h8005, 32'h0, 1, 1, 32'h0, raw);
            check("rand_c_cvalid", 32'(c_cvalid), 32'd1);
            check("rand_c_crc", 32'(c_crc), exp);
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
